gerenciador_alarme_temperatura: RTL and testbench
=================================================

// Module: gerenciador_alarme_temperatura
// PURPOSE
//  Downstream stage of the temperature control system. It consumes the raw
//  over-temperature flag alarmeSonoroTemperatura, which is asserted when any
//  sensor exceeds its limit. It filters that flag for persistence and latches
//  it into an operator-visible alarm. It drives the siren with a beep pattern,
//  handles the control-room acknowledge and escalates to a shutdown request
//  when the alarm is not acknowledged in time.
// PARAMETERS
//  PERSIST      4   consecutive high samples of the flag required to raise the alarm (>=1)
//  BEEP_PERIOD  8   siren period in cycles; high for first BEEP_PERIOD/2 (even, >=2)
//  ESCAL_CYCLES 64  cycles spent in ALARME without an ack before escalation (>=1)
//  CLEAR_CYCLES 4   consecutive low samples of the flag needed to leave RECONHECIDO (>=1)
// PORTS
//  clk                      in   1  system clock, all logic on rising edge
//  rst                      in   1  synchronous, active-high reset
//  alarmeSonoroTemperatura  in   1  raw over-temperature flag (combinational, unsynchronised)
//  botaoReconhecer          in   1  operator acknowledge button level
//  alarmeAtivo              out  1  latched alarm indicator
//  sireneSaida              out  1  siren drive
//  pedidoDesligamento       out  1  reactor shutdown request, sticky
//  estadoAlarme             out  3  current state encoding, for the panel display
// BEHAVIOUR
//  - Reset: one synchronous clock with rst=1. After it: state=NORMAL, all counters=0,
//    ack-edge register=0, outputs all 0. rst mid-operation, including from ESCALADO,
//    returns to this state on the same edge.
//  - Input sampling: both inputs pass through a 2-flop synchroniser, giving 2 cycles of
//    input latency. Ack acts only on its rising edge, derived from the synchronised
//    level vs its previous value. A held button counts once.
//  - Outputs are Moore: registered and a function of state and the beep counter.
//  - States and transitions:
//    NORMAL: outputs 0. Flag=1 -> CONFIRMANDO, with persistence count=1.
//      If PERSIST=1 -> ALARME directly.
//    CONFIRMANDO: flag=0 -> NORMAL, count cleared. Flag=1 -> count+1. When count
//      reaches PERSIST -> ALARME. Ack is ignored.
//    ALARME: alarmeAtivo=1. Siren toggles per the beep counter. The escalation counter
//      increments each cycle.
//      - Ack edge with flag=1 -> RECONHECIDO.
//      - Ack edge with flag=0 -> NORMAL.
//      - Escalation counter reaching ESCAL_CYCLES-1 with no ack -> ESCALADO.
//      - Ack edge and escalation terminal count in the same cycle: ack wins.
//      - Flag falling without an ack keeps the state in ALARME (latched).
//    RECONHECIDO: alarmeAtivo=1, siren=0. Flag low for CLEAR_CYCLES consecutive cycles
//      -> NORMAL. Any flag=1 clears the clear counter. Further ack edges are ignored.
//    ESCALADO: alarmeAtivo=1, siren=1 continuously, pedidoDesligamento=1. Exit only
//      by rst. Ack is ignored.
//  - Beep counter: counts 0..BEEP_PERIOD-1 and wraps to 0. It is zeroed on entry to
//    ALARME, so the siren is high on the first ALARME cycle.
//  - Counters:
//    - Widths are $clog2(param+1).
//    - Every counter is zeroed on every state change.
//    - Counters saturate and never wrap, except the beep counter.
//  - estadoAlarme encoding: NORMAL=0, CONFIRMANDO=1, ALARME=2, RECONHECIDO=3,
//    ESCALADO=4. Codes 5-7 are illegal and recover to NORMAL on the next edge.
// STRUCTURE
//  - Package pkg_alarme_temperatura holds:
//    - the state typedef and its encodings;
//    - the default parameter constants.
//  - Sub-module sincronizador_borda: 2-flop synchroniser plus rising-edge detector,
//    instantiated twice. The flag instance does not use the edge output.
//  - The FSM, counters and output registers live in this module.
// TESTING
//  - Reset: rst=1 for 1 cycle with flag=1 -> all outputs 0, estadoAlarme=0 the next cycle.
//  - Glitch: flag high 3 cycles (PERSIST=4) -> reaches CONFIRMANDO then NORMAL;
//    alarmeAtivo never 1.
//  - Alarm and ack:
//    - Flag held high -> alarmeAtivo=1 exactly 2+4 cycles after the first high sample.
//    - Siren pattern is 1111 0000.
//    - Ack pulse -> siren 0, state RECONHECIDO.
//    - Flag low 4 cycles -> NORMAL.
//  - Escalation: flag high, no ack -> pedidoDesligamento=1 and siren steady 1 at 64
//    cycles after ALARME entry. Later ack pulses and flag drop leave pedidoDesligamento=1
//    until rst.
//  - Priority: ack edge coincides with the escalation terminal cycle -> RECONHECIDO,
//    pedidoDesligamento stays 0.
//  - Latched alarm: flag drops while in ALARME -> alarm stays on; ack -> NORMAL directly.
//    A held ack button produces only one transition.

Source files
------------

// File: rtl/gerenciador_alarme_temperatura_pkg.sv
// Shared types and default parameters for the temperature alarm manager.
package pkg_alarme_temperatura;

    // Encodings are also the values shown on the panel display.
    typedef enum logic [2:0] {
        ST_NORMAL      = 3'd0,
        ST_CONFIRMANDO = 3'd1,
        ST_ALARME      = 3'd2,
        ST_RECONHECIDO = 3'd3,
        ST_ESCALADO    = 3'd4
    } estado_t;

    localparam int PERSIST_DEF      = 4;
    localparam int BEEP_PERIOD_DEF  = 8;
    localparam int ESCAL_CYCLES_DEF = 64;
    localparam int CLEAR_CYCLES_DEF = 4;

endpackage

// File: rtl/gerenciador_alarme_temperatura_if.sv
// Signal bundle between the alarm manager and its surroundings
// (raw over-temperature flag, operator button, panel and siren outputs).
interface gerenciador_alarme_temperatura_if;

    logic       alarmeSonoroTemperatura;
    logic       botaoReconhecer;
    logic       alarmeAtivo;
    logic       sireneSaida;
    logic       pedidoDesligamento;
    logic [2:0] estadoAlarme;

    // Environment side: drives the flag and the button, watches the outputs.
    modport master (
        output alarmeSonoroTemperatura,
        output botaoReconhecer,
        input  alarmeAtivo,
        input  sireneSaida,
        input  pedidoDesligamento,
        input  estadoAlarme
    );

    // Alarm manager side.
    modport slave (
        input  alarmeSonoroTemperatura,
        input  botaoReconhecer,
        output alarmeAtivo,
        output sireneSaida,
        output pedidoDesligamento,
        output estadoAlarme
    );

endinterface

// File: rtl/gerenciador_alarme_temperatura_sincronizador_borda.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge
// pulse derived from the synchronised level and its previous value.
module sincronizador_borda (
    input  logic clk,
    input  logic rst,
    input  logic dado_i,
    output logic nivel_o,
    output logic borda_o
);

    logic meta_q;
    logic sinc_q;
    logic ant_q;

    // Synchroniser chain and previous-level register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
            ant_q  <= 1'b0;
        end else begin
            meta_q <= dado_i;
            sinc_q <= meta_q;
            ant_q  <= sinc_q;
        end
    end

    assign nivel_o = sinc_q;
    assign borda_o = sinc_q & ~ant_q;

endmodule

// File: rtl/gerenciador_alarme_temperatura.sv
// Temperature alarm manager: filters the raw over-temperature flag for
// persistence, latches an operator alarm, drives a beeping siren, takes the
// control-room acknowledge and escalates to a sticky shutdown request when
// the alarm is left unacknowledged.
//
// state        | meaning
// NORMAL       | no alarm, waiting for the flag
// CONFIRMANDO  | flag seen, counting consecutive high samples
// ALARME       | alarm latched, siren beeping, escalation timer running
// RECONHECIDO  | acknowledged, siren off, waiting for the flag to stay low
// ESCALADO     | unacknowledged too long, shutdown requested until reset
module gerenciador_alarme_temperatura
    import pkg_alarme_temperatura::*;
#(
    parameter int PERSIST      = PERSIST_DEF,
    parameter int BEEP_PERIOD  = BEEP_PERIOD_DEF,
    parameter int ESCAL_CYCLES = ESCAL_CYCLES_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input logic                             clk,
    input logic                             rst,
    gerenciador_alarme_temperatura_if.slave alarme_if
);

    localparam int PW = $clog2(PERSIST + 1);
    localparam int BW = $clog2(BEEP_PERIOD + 1);
    localparam int EW = $clog2(ESCAL_CYCLES + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    localparam logic [PW-1:0] PERSIST_M1 = PW'(PERSIST - 1);
    localparam logic [BW-1:0] BEEP_M1    = BW'(BEEP_PERIOD - 1);
    localparam logic [BW-1:0] BEEP_HALF  = BW'(BEEP_PERIOD / 2);
    localparam logic [EW-1:0] ESCAL_M1   = EW'(ESCAL_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_M1   = CW'(CLEAR_CYCLES - 1);

    logic flag_s;
    logic flag_borda_unused;
    logic ack_borda;
    logic ack_nivel_unused;

    estado_t       estado_q, estado_d;
    logic [PW-1:0] persist_q, persist_d;
    logic [BW-1:0] beep_q, beep_d;
    logic [EW-1:0] escal_q, escal_d;
    logic [CW-1:0] clear_q, clear_d;

    logic       ativo_q, ativo_d;
    logic       sirene_q, sirene_d;
    logic       pedido_q, pedido_d;
    logic [2:0] painel_q, painel_d;

    sincronizador_borda u_sinc_flag (
        .clk     (clk),
        .rst     (rst),
        .dado_i  (alarme_if.alarmeSonoroTemperatura),
        .nivel_o (flag_s),
        .borda_o (flag_borda_unused)
    );

    sincronizador_borda u_sinc_ack (
        .clk     (clk),
        .rst     (rst),
        .dado_i  (alarme_if.botaoReconhecer),
        .nivel_o (ack_nivel_unused),
        .borda_o (ack_borda)
    );

    // State register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= ST_NORMAL;
            persist_q <= '0;
            beep_q    <= '0;
            escal_q   <= '0;
            clear_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            persist_q <= persist_d;
            beep_q    <= beep_d;
            escal_q   <= escal_d;
            clear_q   <= clear_d;
        end
    end

    // Next-state and counter update; every state change restarts all counters.
    always_comb begin
        estado_d  = estado_q;
        persist_d = persist_q;
        beep_d    = beep_q;
        escal_d   = escal_q;
        clear_d   = clear_q;

        case (estado_q)
            ST_NORMAL: begin
                if (flag_s) begin
                    estado_d = (PERSIST == 1) ? ST_ALARME : ST_CONFIRMANDO;
                end
            end
            ST_CONFIRMANDO: begin
                if (!flag_s) begin
                    estado_d = ST_NORMAL;
                end else if (persist_q >= PERSIST_M1) begin
                    estado_d = ST_ALARME;
                end else begin
                    persist_d = persist_q + 1'b1;
                end
            end
            ST_ALARME: begin
                beep_d = (beep_q >= BEEP_M1) ? '0 : beep_q + 1'b1;
                // Acknowledge takes priority over the escalation terminal count.
                if (ack_borda) begin
                    estado_d = flag_s ? ST_RECONHECIDO : ST_NORMAL;
                end else if (escal_q >= ESCAL_M1) begin
                    estado_d = ST_ESCALADO;
                end else begin
                    escal_d = escal_q + 1'b1;
                end
            end
            ST_RECONHECIDO: begin
                if (flag_s) begin
                    clear_d = '0;
                end else if (clear_q >= CLEAR_M1) begin
                    estado_d = ST_NORMAL;
                end else begin
                    clear_d = clear_q + 1'b1;
                end
            end
            ST_ESCALADO: begin
                estado_d = ST_ESCALADO;
            end
            default: begin
                estado_d = ST_NORMAL;
            end
        endcase

        if (estado_d != estado_q) begin
            persist_d = '0;
            beep_d    = '0;
            escal_d   = '0;
            clear_d   = '0;
            // Entering CONFIRMANDO already accounts for the sample that caused it.
            if (estado_d == ST_CONFIRMANDO) begin
                persist_d = PW'(1);
            end
        end
    end

    // Moore output decode from the current state and beep phase.
    always_comb begin
        ativo_d  = 1'b0;
        sirene_d = 1'b0;
        pedido_d = 1'b0;
        painel_d = estado_q;
        case (estado_q)
            ST_ALARME: begin
                ativo_d  = 1'b1;
                sirene_d = (beep_q < BEEP_HALF);
            end
            ST_RECONHECIDO: begin
                ativo_d = 1'b1;
            end
            ST_ESCALADO: begin
                ativo_d  = 1'b1;
                sirene_d = 1'b1;
                pedido_d = 1'b1;
            end
            default: begin
                ativo_d = 1'b0;
            end
        endcase
    end

    // Output registers, so the panel and siren never see decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ativo_q  <= 1'b0;
            sirene_q <= 1'b0;
            pedido_q <= 1'b0;
            painel_q <= 3'd0;
        end else begin
            ativo_q  <= ativo_d;
            sirene_q <= sirene_d;
            pedido_q <= pedido_d;
            painel_q <= painel_d;
        end
    end

    assign alarme_if.alarmeAtivo        = ativo_q;
    assign alarme_if.sireneSaida        = sirene_q;
    assign alarme_if.pedidoDesligamento = pedido_q;
    assign alarme_if.estadoAlarme       = painel_q;

endmodule

// File: tb/tb_gerenciador_alarme_temperatura.sv
// Bench for the temperature alarm manager: directed scenarios followed by
// random flag/button/reset traffic, all compared against a behavioural model.
module tb_gerenciador_alarme_temperatura;

    localparam int PERSIST = 4;
    localparam int BEEP    = 8;
    localparam int ESCAL   = 64;
    localparam int CLEAR   = 4;

    localparam int M_NORMAL = 0;
    localparam int M_CONF   = 1;
    localparam int M_ALARM  = 2;
    localparam int M_ACK    = 3;
    localparam int M_ESC    = 4;

    typedef struct packed {
        logic       ativo;
        logic       sirene;
        logic       pedido;
        logic [2:0] estado;
    } saida_t;

    logic clk = 1'b0;
    logic rst;

    gerenciador_alarme_temperatura_if alarme_if ();

    gerenciador_alarme_temperatura #(
        .PERSIST      (PERSIST),
        .BEEP_PERIOD  (BEEP),
        .ESCAL_CYCLES (ESCAL),
        .CLEAR_CYCLES (CLEAR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alarme_if (alarme_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit iniciado = 1'b0;
    saida_t exp_q[$];

    // Reference model: mode plus elapsed-time style bookkeeping.
    int modo      = M_NORMAL;
    int altos     = 0;
    int t_alarme  = 0;
    int baixos    = 0;
    bit hf [3];
    bit ha [3];

    function automatic saida_t saida_modelo(input int m, input int t);
        saida_t s;
        s = '0;
        case (m)
            M_CONF:  s.estado = 3'd1;
            M_ALARM: begin
                s.ativo  = 1'b1;
                s.sirene = ((t % BEEP) < (BEEP / 2));
                s.estado = 3'd2;
            end
            M_ACK: begin
                s.ativo  = 1'b1;
                s.estado = 3'd3;
            end
            M_ESC: begin
                s.ativo  = 1'b1;
                s.sirene = 1'b1;
                s.pedido = 1'b1;
                s.estado = 3'd4;
            end
            default: s.estado = 3'd0;
        endcase
        return s;
    endfunction

    // Advance the model by one clock edge with the inputs applied for that edge.
    task automatic passo_modelo(input bit r, input bit f, input bit a);
        saida_t s;
        bit fl;
        bit ae;
        if (r) begin
            modo = M_NORMAL; altos = 0; t_alarme = 0; baixos = 0;
            for (int k = 0; k < 3; k++) begin
                hf[k] = 1'b0;
                ha[k] = 1'b0;
            end
            s = '0;
        end else begin
            s  = saida_modelo(modo, t_alarme);
            fl = hf[1];
            ae = ha[1] && !ha[2];
            case (modo)
                M_NORMAL: if (fl) begin
                    if (PERSIST == 1) begin modo = M_ALARM; t_alarme = 0; end
                    else begin modo = M_CONF; altos = 1; end
                end
                M_CONF: begin
                    if (!fl) modo = M_NORMAL;
                    else begin
                        altos++;
                        if (altos >= PERSIST) begin modo = M_ALARM; t_alarme = 0; end
                    end
                end
                M_ALARM: begin
                    if (ae) begin
                        if (fl) begin modo = M_ACK; baixos = 0; end
                        else modo = M_NORMAL;
                    end else if (t_alarme == ESCAL - 1) modo = M_ESC;
                    else t_alarme++;
                end
                M_ACK: begin
                    if (fl) baixos = 0;
                    else begin
                        baixos++;
                        if (baixos == CLEAR) modo = M_NORMAL;
                    end
                end
                default: ;
            endcase
            hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = f;
            ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = a;
        end
        exp_q.push_back(s);
    endtask

    task automatic ciclo(input bit r, input bit f, input bit a);
        @(negedge clk);
        rst = r;
        alarme_if.alarmeSonoroTemperatura = f;
        alarme_if.botaoReconhecer = a;
        passo_modelo(r, f, a);
        iniciado = 1'b1;
    endtask

    task automatic verifica(input string nome, input logic [2:0] real_v, input logic [2:0] esp);
        checks++;
        if (real_v !== esp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nome, $time, real_v, esp);
        end
    endtask

    // Monitor: one output sample per edge, compared with the queued expectation.
    initial begin
        saida_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                verifica("alarmeAtivo", {2'b00, alarme_if.alarmeAtivo}, {2'b00, e.ativo});
                verifica("sireneSaida", {2'b00, alarme_if.sireneSaida}, {2'b00, e.sirene});
                verifica("pedidoDesligamento", {2'b00, alarme_if.pedidoDesligamento}, {2'b00, e.pedido});
                verifica("estadoAlarme", alarme_if.estadoAlarme, e.estado);
            end else if (iniciado) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, expected one", $time);
            end
        end
    end

    task automatic espera_modo(input string nome, input int alvo_modo, input int alvo_t);
        int n;
        n = 0;
        while (!(modo == alvo_modo && (alvo_t < 0 || t_alarme == alvo_t)) && n < 300) begin
            ciclo(1'b0, 1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s timeout: got %0d cycles, expected fewer than 300", nome, n);
        end
    endtask

    initial begin
        bit f_r;
        bit a_r;
        bit r_r;
        int ack_pct;
        rst = 1'b1;
        alarme_if.alarmeSonoroTemperatura = 1'b0;
        alarme_if.botaoReconhecer = 1'b0;

        // Reset with the flag high.
        ciclo(1'b1, 1'b1, 1'b0);
        repeat (4) ciclo(1'b0, 1'b0, 1'b0);

        // Three-cycle glitch must not raise the alarm.
        repeat (3) ciclo(1'b0, 1'b1, 1'b0);
        repeat (8) ciclo(1'b0, 1'b0, 1'b0);

        // Alarm, siren pattern, acknowledge with flag high, then clear.
        repeat (18) ciclo(1'b0, 1'b1, 1'b0);
        ciclo(1'b0, 1'b1, 1'b1);
        repeat (4) ciclo(1'b0, 1'b1, 1'b0);
        repeat (10) ciclo(1'b0, 1'b0, 1'b0);

        // Latched alarm: flag drops, ack goes straight to NORMAL.
        repeat (12) ciclo(1'b0, 1'b1, 1'b0);
        repeat (4) ciclo(1'b0, 1'b0, 1'b0);
        repeat (6) ciclo(1'b0, 1'b0, 1'b1);
        repeat (4) ciclo(1'b0, 1'b0, 1'b0);

        // Held button across a new alarm must not acknowledge it.
        repeat (4) ciclo(1'b0, 1'b0, 1'b1);
        repeat (16) ciclo(1'b0, 1'b1, 1'b1);
        repeat (4) ciclo(1'b0, 1'b0, 1'b1);
        ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b1);
        repeat (8) ciclo(1'b0, 1'b0, 1'b0);

        // Ack edge lands on the escalation terminal cycle.
        espera_modo("priority_wait", M_ALARM, ESCAL - 3);
        repeat (2) ciclo(1'b0, 1'b1, 1'b1);
        repeat (6) ciclo(1'b0, 1'b1, 1'b0);
        repeat (8) ciclo(1'b0, 1'b0, 1'b0);

        // Escalation, then ack and flag drop must not release it.
        espera_modo("escalation_wait", M_ESC, -1);
        repeat (5) ciclo(1'b0, 1'b1, 1'b0);
        ciclo(1'b0, 1'b1, 1'b1);
        repeat (3) ciclo(1'b0, 1'b1, 1'b0);
        ciclo(1'b0, 1'b0, 1'b1);
        repeat (10) ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 1'b0, 1'b0);
        repeat (3) ciclo(1'b0, 1'b0, 1'b0);

        // Random traffic with alternating acknowledge activity.
        f_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ack_pct = ((i / 500) % 2 == 1) ? 0 : 5;
            if ($urandom_range(0, 99) < 8) f_r = ~f_r;
            a_r = ($urandom_range(0, 99) < ack_pct);
            r_r = ($urandom_range(0, 399) == 0);
            ciclo(r_r, f_r, a_r);
        end

        @(posedge clk);
        #3;
        iniciado = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
